lut_divider: RTL
================

# lut_divider

Sequential 16-bit unsigned integer divider built around a piecewise reciprocal seed table. It normalises the divisor, forms a quotient estimate by multiply-and-shift, and refines it once. It then corrects the remainder to an exact result. It sits in the measurement datapath (ratio and frequency computations) behind a valid/ready request port and drives a valid/ready result port.

## Interface
- `MAX_CORR`, default 4: upper bound on correction cycles; exceeding it sets `corr_err`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: block can accept; high only in IDLE.
- `dividend` in 16: unsigned numerator.
- `divisor` in 16: unsigned denominator.
- `out_valid` out 1: result valid; held until accepted.
- `out_ready` in 1: consumer accepts result.
- `quotient` out 16: floor(dividend/divisor); 0xFFFF on divide-by-zero.
- `remainder` out 16: dividend − quotient·divisor; equals dividend on divide-by-zero.
- `div_by_zero` out 1: divisor was 0.
- `corr_err` out 1: correction bound hit (must never occur for legal operation).

## Operation
- Reset values:
  - `in_ready`=0 during reset, then 1 in IDLE.
  - `out_valid`, `quotient`, `remainder`, `div_by_zero`, `corr_err` are all 0.
- FSM states: IDLE → NORM → EST → REFINE → CORR → DONE → IDLE.
- **IDLE**: on `in_valid&in_ready`, latch the operands.
  - If divisor==0, go to DONE with q=0xFFFF, r=dividend, `div_by_zero`=1.
  - Otherwise go to NORM.
- **NORM**:
  - s = leading-zero count of divisor (0..15).
  - dn = divisor<<s, so dn ∈ [2^15, 2^16).
  - i = dn[14:7].
- **EST**:
  - T = seed[i], where seed[i] = floor(2^25/(257+i)), 17 bits, range 65536..130561.
  - q1 = (dividend·T) >> (32−s), using a 33-bit product.
  - T underestimates 2^32/dn, so q1 ≤ true quotient.
- **REFINE**:
  - r1 = dividend − q1·divisor (≥0).
  - q2 = q1 + ((r1·T) >> (32−s)).
  - r2 = dividend − q2·divisor (≥0).
- **CORR**: one compare per cycle.
  - If r ≥ divisor: q+=1, r−=divisor, increment the correction count.
  - Otherwise go to DONE.
  - If the count reaches MAX_CORR, go to DONE with `corr_err`=1.
  - Seed accuracy bounds corrections to ≤3.
- **DONE**: `out_valid`=1; outputs are stable while `out_ready`=0. On `out_valid&out_ready`, go to IDLE and drop `out_valid`.
- All arithmetic is unsigned. The quotient is never saturated except in the divide-by-zero case.

## Timing
- Cycle 0 is the accepting edge.
- Normal path: `out_valid` rises at cycle 5+c, where c is the number of corrections (0..3). The maximum is cycle 8.
- Divide-by-zero: `out_valid` rises at cycle 1.
- Zero bubble between the result handshake and the next accept is not required. `in_ready` rises the cycle after `out_valid&out_ready`.
- Only one operation is in flight; `in_valid` is ignored outside IDLE.
- Reset asserted mid-operation:
  - All state returns to IDLE immediately (asynchronous).
  - The partial result is discarded and no `out_valid` is produced.
- `out_ready` high while `out_valid` is low has no effect.

## Configuration
- `LUT_DIV_STATS_EN` defined adds the ports `stat_ops` (out 32) and `stat_max_corr` (out 3):
  - `stat_ops` counts completed result handshakes and wraps at 2^32.
  - `stat_max_corr` holds the largest c seen.
  - Both reset to 0.
- `LUT_DIV_STATS_EN` undefined: these ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `lut_div_pkg`:
  - the FSM state enum;
  - `DW`=16, `SEED_IDX_W`=8, `SEED_W`=17, `CORR_W`=3.
- Sub-module `recip_seed_rom`: combinational, 8-bit index to 17-bit seed, contents per the seed formula. The ROM may be generated at elaboration time.

## Test plan
- 1000/7 → quotient 142, remainder 6, `div_by_zero`=0, `out_valid` at cycle ≥5.
- 65535/1 (s=15) → quotient 65535, remainder 0; 65535/65535 → quotient 1, remainder 0.
- 12345/0 → quotient 0xFFFF, remainder 12345, `div_by_zero`=1, `out_valid` at cycle 1.
- 5/65535 → quotient 0, remainder 5; `out_ready` held low 10 cycles → outputs stable, `in_ready`=0, then release → `in_ready`=1 next cycle.
- 100k random and exhaustive-corner operands against a golden model → exact match, `corr_err` never set, c ≤ 3.
- `rst_n` pulsed during CORR → `out_valid`=0 and `in_ready`=1 after release; the next request 200/3 returns quotient 66, remainder 2.

Source files
------------

// File: rtl/lut_div_pkg.sv
// Shared types and sizing for the LUT-seeded reciprocal divider.
package lut_div_pkg;

    localparam int DW         = 16;
    localparam int SEED_IDX_W = 8;
    localparam int SEED_W     = 17;
    localparam int CORR_W     = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_NORM   = 3'd1,
        ST_EST    = 3'd2,
        ST_REFINE = 3'd3,
        ST_CORR   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Leading-zero count of a non-zero 16-bit value; the highest set bit wins.
    function automatic logic [3:0] lzc16(input logic [DW-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int k = 0; k < DW; k++) begin
            if (v[k]) n = 4'(DW - 1 - k);
        end
        return n;
    endfunction

endpackage

// File: rtl/recip_seed_rom.sv
// Reciprocal seed table: seed[i] = floor(2^25 / (257 + i)), built at elaboration.
module recip_seed_rom
    import lut_div_pkg::*;
(
    input  logic [SEED_IDX_W-1:0] idx,
    output logic [SEED_W-1:0]     seed
);

    logic [SEED_W-1:0] seed_tab_s [1 << SEED_IDX_W];

    for (genvar g = 0; g < (1 << SEED_IDX_W); g++) begin : g_seed
        assign seed_tab_s[g] = SEED_W'(32'd33554432 / (32'd257 + 32'(g)));
    end

    assign seed = seed_tab_s[idx];

endmodule

// File: rtl/lut_divider.sv
// Sequential 16-bit unsigned divider: normalise, seed estimate, one refinement, exact correction.
// Optional statistics ports are enabled by defining LUT_DIV_STATS_EN.
module lut_divider
    import lut_div_pkg::*;
#(
    parameter int MAX_CORR = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          div_by_zero,
`ifdef LUT_DIV_STATS_EN
    output logic [31:0]   stat_ops,
    output logic [2:0]    stat_max_corr,
`endif
    output logic          corr_err
);

    state_t              state_r;
    logic                in_ready_r;
    logic                out_valid_r;
    logic [DW-1:0]       dividend_r;
    logic [DW-1:0]       divisor_r;
    logic [3:0]          shift_r;
    logic [SEED_IDX_W-1:0] idx_r;
    logic [DW-1:0]       q_r;
    logic [DW-1:0]       r_r;
    logic [CORR_W-1:0]   corr_cnt_r;
    logic                dbz_r;
    logic                cerr_r;
    logic [DW-1:0]       quotient_r;
    logic [DW-1:0]       remainder_r;
    logic                div_by_zero_r;
    logic                corr_err_r;

    logic [3:0]          lz_s;
    logic [DW-1:0]       dn_s;
    logic [SEED_IDX_W-1:0] idx_s;
    logic [SEED_W-1:0]   seed_s;
    logic [5:0]          shamt_s;
    logic [32:0]         est_prod_s;
    logic [DW-1:0]       q1_s;
    logic [DW-1:0]       r1_s;
    logic [32:0]         ref_prod_s;
    logic [DW-1:0]       q2_s;
    logic [DW-1:0]       r2_s;
    logic [CORR_W-1:0]   corr_next_s;
    logic                load_s;
    logic                handshake_s;

    recip_seed_rom u_seed (
        .idx  (idx_r),
        .seed (seed_s)
    );

    // Normalisation: dn = divisor << lzc keeps the MSB set, so dn[14:7] picks the segment.
    assign lz_s  = lzc16(divisor_r);
    assign dn_s  = divisor_r << lz_s;
    assign idx_s = SEED_IDX_W'(dn_s >> 7);

    // The seed approximates 2^32/dn from below, so every estimate undershoots the quotient.
    assign shamt_s    = 6'd32 - {2'b00, shift_r};
    assign est_prod_s = 33'(dividend_r) * 33'(seed_s);
    assign q1_s       = DW'(est_prod_s >> shamt_s);

    // q*divisor never exceeds the dividend, so the low 16 bits of the product are exact.
    assign r1_s       = dividend_r - q_r * divisor_r;
    assign ref_prod_s = 33'(r1_s) * 33'(seed_s);
    assign q2_s       = q_r + DW'(ref_prod_s >> shamt_s);
    assign r2_s       = dividend_r - q2_s * divisor_r;

    assign corr_next_s = corr_cnt_r + 3'd1;
    assign load_s      = (state_r == ST_DONE) && !out_valid_r;
    assign handshake_s = out_valid_r && out_ready;

    // Control FSM with datapath registers and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            in_ready_r    <= 1'b0;
            out_valid_r   <= 1'b0;
            dividend_r    <= 16'd0;
            divisor_r     <= 16'd0;
            shift_r       <= 4'd0;
            idx_r         <= 8'd0;
            q_r           <= 16'd0;
            r_r           <= 16'd0;
            corr_cnt_r    <= 3'd0;
            dbz_r         <= 1'b0;
            cerr_r        <= 1'b0;
            quotient_r    <= 16'd0;
            remainder_r   <= 16'd0;
            div_by_zero_r <= 1'b0;
            corr_err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        in_ready_r <= 1'b0;
                        dividend_r <= dividend;
                        divisor_r  <= divisor;
                        corr_cnt_r <= 3'd0;
                        cerr_r     <= 1'b0;
                        if (divisor == 16'd0) begin
                            q_r     <= 16'hFFFF;
                            r_r     <= dividend;
                            dbz_r   <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            dbz_r   <= 1'b0;
                            state_r <= ST_NORM;
                        end
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_NORM: begin
                    shift_r <= lz_s;
                    idx_r   <= idx_s;
                    state_r <= ST_EST;
                end
                ST_EST: begin
                    q_r     <= q1_s;
                    state_r <= ST_REFINE;
                end
                ST_REFINE: begin
                    q_r     <= q2_s;
                    r_r     <= r2_s;
                    state_r <= ST_CORR;
                end
                ST_CORR: begin
                    if (r_r >= divisor_r) begin
                        q_r        <= q_r + 16'd1;
                        r_r        <= r_r - divisor_r;
                        corr_cnt_r <= corr_next_s;
                        if (corr_next_s == CORR_W'(MAX_CORR)) begin
                            cerr_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_CORR;
                        end
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!out_valid_r) begin
                        out_valid_r   <= 1'b1;
                        quotient_r    <= q_r;
                        remainder_r   <= r_r;
                        div_by_zero_r <= dbz_r;
                        corr_err_r    <= cerr_r;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef LUT_DIV_STATS_EN
    logic [31:0] stat_ops_r;
    logic [2:0]  stat_max_corr_r;

    // Completed-handshake counter and high-water mark of corrections per result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops_r      <= 32'd0;
            stat_max_corr_r <= 3'd0;
        end else begin
            if (handshake_s) begin
                stat_ops_r <= stat_ops_r + 32'd1;
            end else begin
                stat_ops_r <= stat_ops_r;
            end
            if (load_s && (corr_cnt_r > stat_max_corr_r)) begin
                stat_max_corr_r <= corr_cnt_r;
            end else begin
                stat_max_corr_r <= stat_max_corr_r;
            end
        end
    end

    assign stat_ops      = stat_ops_r;
    assign stat_max_corr = stat_max_corr_r;
`endif

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = div_by_zero_r;
    assign corr_err    = corr_err_r;

endmodule
